// File: rtl/cnt_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
// Shared constants and types for the prescaled modulo counter family.
//   CNT_WIDTH / CNT_MOD / CNT_DIV_W : default counter geometry (mod-60 seconds).
//   CLK_HZ                          : divisor that turns a 50 MHz clk into 1 Hz.
//   dir_e                           : count direction encoding on the 'up' pin.
// -----------------------------------------------------------------------------
package cnt_pkg;

   localparam int CNT_WIDTH = 6;
   localparam int CNT_MOD   = 60;
   localparam int CNT_DIV_W = 32;

   localparam int unsigned CLK_HZ = 50_000_000;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage : cnt_pkg

// File: rtl/prescaled_mod_counter_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Runtime-programmable prescaler: emits a one-clk tick once every num enabled
// clocks (num = 0 and num = 1 both tick on every enabled clock).
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high (clears div_cnt)
//   en   : advance enable; div_cnt holds and tick is 0 while low
//   clr  : synchronous restart of div_cnt, independent of en
//   num  : divisor
//   tick : prescaler pulse decoded from the registered div_cnt
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] num,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt;
   logic             at_end;

   // The >= compare (instead of ==) means a divisor shrunk below the current
   // count ticks on the next enabled clock rather than running the counter all
   // the way round. num <= 1 is handled explicitly so num-1 never underflows.
   assign at_end = (num <= DIV_W'(1)) || (div_cnt >= (num - DIV_W'(1)));
   assign tick   = en && at_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         if (at_end) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule : tick_gen

// File: rtl/prescaled_mod_counter.sv
// -----------------------------------------------------------------------------
// prescaled_mod_counter
// Modulo-MOD up/down counter advanced by an internal prescaler tick, with
// synchronous load (clamped to MOD-1), enable, and a one-clk carry pulse on
// wrap/borrow for cascading stages (seconds -> minutes -> hours).
// Parameters: WIDTH (counter bits), MOD (modulus, 2..2**WIDTH), DIV_W (divisor
// width).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   en             : count enable (prescaler and counter hold when low)
//   up             : 1 = increment, 0 = decrement
//   load, load_val : synchronous load strobe and value (wins over tick)
//   num            : prescale divisor
//   out            : registered count
//   tick           : prescaler pulse
//   carry          : registered wrap/borrow pulse, high with the wrapped value
// Optional build macro CNT_LAP_EN adds:
//   lap            : capture strobe
//   lap_out        : captured (pre-update) count
// -----------------------------------------------------------------------------
module prescaled_mod_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH,
   parameter int MOD   = CNT_MOD,
   parameter int DIV_W = CNT_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [DIV_W-1:0] num,
`ifdef CNT_LAP_EN
   input  logic             lap,
   output logic [WIDTH-1:0] lap_out,
`endif
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             carry
);

   localparam longint MOD_LIMIT = longint'(1) << WIDTH;

   generate
      if (MOD < 2 || longint'(MOD) > MOD_LIMIT) begin : g_bad_mod
         $error("prescaled_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

   dir_e             dir;
   logic [WIDTH-1:0] load_clamped;

   assign dir          = dir_e'(up);
   assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .num  (num),
      .tick (tick)
   );

   // tick already includes en, so the else branch covers both "enabled but
   // no tick" and "disabled": out holds and carry drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out   <= '0;
         carry <= 1'b0;
      end else if (load) begin
         out   <= load_clamped;
         carry <= 1'b0;
      end else if (tick) begin
         if (dir == DIR_UP) begin
            if (out == MAX_VAL) begin
               out   <= '0;
               carry <= 1'b1;
            end else begin
               out   <= out + WIDTH'(1);
               carry <= 1'b0;
            end
         end else begin
            if (out == '0) begin
               out   <= MAX_VAL;
               carry <= 1'b1;
            end else begin
               out   <= out - WIDTH'(1);
               carry <= 1'b0;
            end
         end
      end else begin
         carry <= 1'b0;
      end
   end

`ifdef CNT_LAP_EN
   // Captures the count as it stands before this edge's update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_out <= '0;
      end else if (lap) begin
         lap_out <= out;
      end
   end
`endif

endmodule : prescaled_mod_counter
